// File: rtl/ins_prefetch_pkg.sv
// Shared constants for the instruction prefetcher: opcode fields, bus widths,
// default fetch origin and the fetch FSM state type.
package ins_prefetch_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int WORD_W = DATA_W + ADDR_W;

  localparam logic [ADDR_W-1:0] DEFAULT_START_ADDR = 18'h0ff00;

  localparam logic [3:0] OP_END  = 4'b0000;
  localparam logic [3:0] OP_BPM  = 4'b0001;
  localparam logic [3:0] OP_REP1 = 4'b0010;
  localparam logic [3:0] OP_REP2 = 4'b0011;
  localparam int         NOTE_BIT = 15;

  typedef enum logic [1:0] {
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_PARKED
  } fetch_state_t;

  function automatic logic is_end_word(input logic [DATA_W-1:0] word);
    return word[15:12] == OP_END;
  endfunction

endpackage

// File: rtl/ins_prefetch_fifo.sv
// Small circular buffer of fetched {data, address} words with occupancy count.
// Flush empties it in one edge; a push while full is only accepted alongside a pop.
module ins_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop   = i_pop && (r_count != '0) && !i_flush;
  assign w_push  = i_push && !i_flush && ((r_count != FULL) || w_pop);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ins_prefetch.sv
// Instruction prefetcher: walks a read-only async SRAM, buffers words in ins_fifo,
// parks on an end word and restarts from a jump target.
module ins_prefetch
  import ins_prefetch_pkg::*;
#(
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] START_ADDR = DEFAULT_START_ADDR,
  parameter int                SRAM_WAIT  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic [ADDR_W-1:0] o_sram_a,
  output logic              o_sram_we,
  output logic              o_sram_ce,
  output logic              o_sram_oe,
  output logic              o_sram_lb,
  output logic              o_sram_ub,
  input  logic [DATA_W-1:0] i_sram_d,
  input  logic              i_jump_valid,
  input  logic [ADDR_W-1:0] i_jump_addr,
  input  logic              i_ins_ready,
  output logic              o_ins_valid,
  output logic [DATA_W-1:0] o_ins_data,
  output logic [ADDR_W-1:0] o_ins_addr,
  output logic              o_end_seen
);

  localparam int         CW        = $clog2(DEPTH) + 1;
  localparam logic [2:0] WAIT_INIT = 3'(SRAM_WAIT - 1);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_fetch_ptr;
  logic [2:0]        r_wait_cnt;
  logic              r_end_seen;

  logic [CW-1:0]     w_count;
  logic [WORD_W-1:0] w_head;
  logic              w_push;
  logic              w_has_free;
  logic              w_transfer;

  assign o_sram_a  = r_fetch_ptr;
  assign o_sram_we = 1'b1;
  assign o_sram_ce = 1'b0;
  assign o_sram_oe = 1'b0;
  assign o_sram_lb = 1'b0;
  assign o_sram_ub = 1'b0;

  // Only one read is ever outstanding and ISSUE is never entered with one in
  // flight, so a free slot here also reserves room for the word about to be read.
  assign w_has_free = w_count < CW'(DEPTH);
  assign w_push     = (r_state == ST_CAPTURE) && !i_jump_valid;
  assign w_transfer = o_ins_valid && i_ins_ready;

  assign o_ins_valid = (w_count != '0);
  assign o_ins_data  = o_ins_valid ? w_head[WORD_W-1:ADDR_W] : '0;
  assign o_ins_addr  = o_ins_valid ? w_head[ADDR_W-1:0]      : '0;
  assign o_end_seen  = r_end_seen;

  ins_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_jump_valid),
    .i_push  (w_push),
    .i_wdata ({i_sram_d, r_fetch_ptr}),
    .i_pop   (w_transfer),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_ISSUE;
      r_fetch_ptr <= START_ADDR;
      r_wait_cnt  <= '0;
      r_end_seen  <= 1'b0;
    end else if (i_jump_valid) begin
      r_state     <= ST_ISSUE;
      r_fetch_ptr <= i_jump_addr;
      r_wait_cnt  <= '0;
      r_end_seen  <= 1'b0;
    end else begin
      case (r_state)
        ST_ISSUE: begin
          if (w_has_free) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= WAIT_INIT;
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == '0) r_state <= ST_CAPTURE;
          else                  r_wait_cnt <= r_wait_cnt - 1'b1;
        end
        ST_CAPTURE: begin
          r_fetch_ptr <= r_fetch_ptr + 1'b1;
          if (is_end_word(i_sram_d)) begin
            r_state    <= ST_PARKED;
            r_end_seen <= 1'b1;
          end else begin
            r_state <= ST_ISSUE;
          end
        end
        ST_PARKED: r_state <= ST_PARKED;
        default:   r_state <= ST_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_prefetch.sv
// Scoreboard bench for ins_prefetch: expected words are queued when a fetch run
// is started and compared as the consumer accepts them.
module tb_ins_prefetch;

  logic        clk = 1'b0;
  logic        rstN;
  logic [17:0] sramA;
  logic        sramWe, sramCe, sramOe, sramLb, sramUb;
  logic [15:0] sramD;
  logic        jumpValid;
  logic [17:0] jumpAddr;
  logic        insReady;
  logic        insValid;
  logic [15:0] insData;
  logic [17:0] insAddr;
  logic        endSeen;

  logic [17:0] extraEnd;
  logic [33:0] expQ[$];
  int          assertCount = 0;
  int          failCount   = 0;

  always #10 clk = ~clk;

  ins_prefetch dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .o_sram_a     (sramA),
    .o_sram_we    (sramWe),
    .o_sram_ce    (sramCe),
    .o_sram_oe    (sramOe),
    .o_sram_lb    (sramLb),
    .o_sram_ub    (sramUb),
    .i_sram_d     (sramD),
    .i_jump_valid (jumpValid),
    .i_jump_addr  (jumpAddr),
    .i_ins_ready  (insReady),
    .o_ins_valid  (insValid),
    .o_ins_data   (insData),
    .o_ins_addr   (insAddr),
    .o_end_seen   (endSeen)
  );

  // SRAM image: two fixed program words, two end words, everything else a note word.
  function automatic logic [15:0] sramWord(input logic [17:0] a, input logic [17:0] endA);
    if (a == 18'h0ff00) return 16'h8123;
    if (a == 18'h0ff01) return 16'h8234;
    if (a == 18'h0ff02) return 16'h0000;
    if (a == endA)      return 16'h0000;
    return {4'h9, a[11:0]};
  endfunction

  always_comb sramD = sramWord(sramA, extraEnd);

  task automatic checkOutput(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expectRun(input logic [17:0] start, input int n);
    logic [17:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      expQ.push_back({sramWord(a, extraEnd), a});
      a = a + 18'd1;
    end
  endtask

  // Single-cycle jump pulse, returning #1 after the edge that takes it.
  task automatic applyStimulus(input logic [17:0] target);
    @(posedge clk); #1;
    jumpAddr  = target;
    jumpValid = 1'b1;
    @(posedge clk); #1;
    jumpValid = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int n;
    for (n = 0; n < 400; n++) begin
      if (endSeen && !insValid && expQ.size() == 0) break;
      @(posedge clk); #1;
    end
    checkOutput({tag, "_drained"}, (n < 400), 1);
  endtask

  task automatic releaseAndTime(input string tag);
    int cyc;
    @(posedge clk); #1;
    rstN = 1'b1;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (insValid) break;
    end
    checkOutput({tag, "_first_valid_cycle"}, cyc, 4);
  endtask

  always @(negedge clk) begin
    if (rstN && insValid && insReady) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_word", insValid, 0);
      end else begin
        logic [33:0] e;
        e = expQ.pop_front();
        checkOutput("word_data", insData, e[33:18]);
        checkOutput("word_addr", insAddr, e[17:0]);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN      = 1'b0;
    jumpValid = 1'b0;
    jumpAddr  = '0;
    insReady  = 1'b0;
    extraEnd  = 18'h3f000;

    // Reset state and fixed strobes
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid",   insValid, 0);
    checkOutput("rst_data",    insData,  0);
    checkOutput("rst_addr",    insAddr,  0);
    checkOutput("rst_end",     endSeen,  0);
    checkOutput("rst_sram_a",  sramA,    18'h0ff00);
    checkOutput("strobes",     {sramWe, sramCe, sramOe, sramLb, sramUb}, 5'b10000);

    // Boot run: three words then park
    insReady = 1'b1;
    expectRun(18'h0ff00, 3);
    releaseAndTime("boot");
    waitDrain("boot");
    checkOutput("boot_end_seen", endSeen, 1);
    checkOutput("boot_park_a",   sramA,   18'h0ff03);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("boot_park_hold", sramA, 18'h0ff03);

    // Jump out of PARKED with the consumer stalled: FIFO fills to DEPTH and holds
    insReady = 1'b0;
    extraEnd = 18'h01006;
    expQ.delete();
    expectRun(18'h01000, 7);
    applyStimulus(18'h01000);
    checkOutput("jmp_park_end_clr", endSeen,  0);
    checkOutput("jmp_park_valid",   insValid, 0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("stall_mid_addr", insAddr, 18'h01000);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("stall_sram_a", sramA,    18'h01004);
    checkOutput("stall_valid",  insValid, 1);
    checkOutput("stall_data",   insData,  16'h9000);
    checkOutput("stall_addr",   insAddr,  18'h01000);
    insReady = 1'b1;
    waitDrain("stall");
    checkOutput("stall_park_a", sramA, 18'h01007);

    // Jump during WAIT with two words buffered
    insReady = 1'b0;
    extraEnd = 18'h02003;
    expQ.delete();
    applyStimulus(18'h02000);
    for (int n = 0; n < 100; n++) begin
      if (sramA == 18'h02002) break;
      @(posedge clk); #1;
    end
    checkOutput("two_buffered_a", sramA, 18'h02002);
    @(posedge clk); #1;
    checkOutput("two_buffered_valid", insValid, 1);
    extraEnd = 18'h0ff12;
    expQ.delete();
    expectRun(18'h0ff10, 3);
    applyStimulus(18'h0ff10);
    checkOutput("wait_jmp_valid", insValid, 0);
    insReady = 1'b1;
    waitDrain("wait_jmp");

    // Fetch pointer wrap at the top of the address space
    extraEnd = 18'h00001;
    expQ.delete();
    expectRun(18'h3fffe, 4);
    applyStimulus(18'h3fffe);
    waitDrain("wrap");
    checkOutput("wrap_park_a", sramA, 18'h00002);

    // Reset asserted while the FSM sits in CAPTURE
    insReady = 1'b0;
    extraEnd = 18'h03100;
    expQ.delete();
    applyStimulus(18'h03000);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_rst_a", sramA, 18'h03000);
    rstN = 1'b0;
    expQ.delete();
    #1;
    checkOutput("midrst_valid",  insValid, 0);
    checkOutput("midrst_data",   insData,  0);
    checkOutput("midrst_end",    endSeen,  0);
    checkOutput("midrst_sram_a", sramA,    18'h0ff00);
    repeat (2) @(posedge clk);
    insReady = 1'b1;
    expectRun(18'h0ff00, 3);
    releaseAndTime("refetch");
    waitDrain("refetch");
    checkOutput("refetch_park_a", sramA, 18'h0ff03);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
